// File: rtl/rijndael_pkg.sv
// rtl/rijndael_pkg.sv - shared types and GF(2^8) helpers for the Rijndael key expansion
package rijndael_pkg;

    typedef logic [31:0] word_t;

    typedef enum logic [1:0] {
        IDLE,
        EMIT,
        EXPAND
    } kx_state_e;

    localparam logic [7:0] RCON_INIT = 8'h01;

    function automatic int nr_f(input int nk);
        return nk + 6;
    endfunction

    function automatic logic [7:0] xtime_f(input logic [7:0] r);
        return {r[6:0], 1'b0} ^ (r[7] ? 8'h1B : 8'h00);
    endfunction

    function automatic logic [7:0] gf_mul_f(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p;
        logic [7:0] x;
        p = 8'h00;
        x = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) p = p ^ x;
            x = xtime_f(x);
        end
        return p;
    endfunction

    // Inverse as x^254 (product of x^2 .. x^128), then the affine map.
    function automatic logic [7:0] sbox_f(input logic [7:0] x);
        logic [7:0] sq;
        logic [7:0] inv;
        sq  = x;
        inv = 8'h01;
        for (int k = 1; k < 8; k++) begin
            sq  = gf_mul_f(sq, sq);
            inv = gf_mul_f(inv, sq);
        end
        return inv ^ {inv[6:0], inv[7]} ^ {inv[5:0], inv[7:6]}
                   ^ {inv[4:0], inv[7:5]} ^ {inv[3:0], inv[7:4]} ^ 8'h63;
    endfunction

    function automatic word_t subword_f(input word_t w);
        return {sbox_f(w[31:24]), sbox_f(w[23:16]), sbox_f(w[15:8]), sbox_f(w[7:0])};
    endfunction

endpackage

// File: rtl/rijndael_keyschedulestep.sv
// rtl/rijndael_keyschedulestep.sv - combinational step producing the next NK key-schedule words
module rijndael_keyschedulestep
    import rijndael_pkg::*;
#(
    parameter int NK = 4
) (
    input  logic [32*NK-1:0] keystate_i,
    input  logic [7:0]       rc_i,
    output logic [32*NK-1:0] keystate_o
);

    word_t prev;
    word_t cur;
    word_t tmp;

    // Word 0 sits in the top 32 bits; the chain runs from the last input word.
    always_comb begin
        keystate_o = '0;
        prev       = keystate_i[31:0];
        cur        = '0;
        tmp        = '0;
        for (int j = 0; j < NK; j++) begin
            if (j == 0) begin
                tmp = subword_f({prev[23:0], prev[31:24]}) ^ {rc_i, 24'h000000};
            end else if (NK == 8 && j == 4) begin
                tmp = subword_f(prev);
            end else begin
                tmp = prev;
            end
            cur = keystate_i[32*(NK-j)-1 -: 32] ^ tmp;
            keystate_o[32*(NK-j)-1 -: 32] = cur;
            prev = cur;
        end
    end

endmodule

// File: rtl/rijndael_keyexpand_iter.sv
// rtl/rijndael_keyexpand_iter.sv - iterative key expansion streaming 128-bit round keys
module rijndael_keyexpand_iter
    import rijndael_pkg::*;
#(
    parameter int NK = 4
) (
    input  logic              clk_i,
    input  logic              rst_ni,
    input  logic              key_valid_i,
    output logic              key_ready_o,
    input  logic [32*NK-1:0]  key_i,
    output logic              rk_valid_o,
    input  logic              rk_ready_i,
    output logic [127:0]      rk_o,
    output logic [3:0]        rk_idx_o,
    output logic              rk_last_o
);

    localparam int         KEYSIZE = 32 * NK;
    localparam int         BUF_W   = 12;
    localparam logic [3:0] NR_IDX  = 4'(nr_f(NK));

    if (!(NK == 4 || NK == 6 || NK == 8)) begin : g_bad_nk
        $error("rijndael_keyexpand_iter: NK must be 4, 6 or 8");
    end

    kx_state_e          state_q, state_d;
    logic [KEYSIZE-1:0] keystate_q, keystate_d;
    logic [7:0]         rcon_q, rcon_d;
    word_t              wbuf_q [BUF_W];
    word_t              wbuf_d [BUF_W];
    logic [3:0]         cnt_q, cnt_d;
    logic [3:0]         rk_idx_q, rk_idx_d;
    logic [KEYSIZE-1:0] step_out;
    int                 off;

    rijndael_keyschedulestep #(.NK(NK)) u_step (
        .keystate_i (keystate_q),
        .rc_i       (rcon_q),
        .keystate_o (step_out)
    );

    assign key_ready_o = (state_q == IDLE);
    assign rk_valid_o  = (state_q == EMIT) && (cnt_q >= 4'd4);
    assign rk_last_o   = rk_valid_o && (rk_idx_q == NR_IDX);
    assign rk_o        = {wbuf_q[0], wbuf_q[1], wbuf_q[2], wbuf_q[3]};
    assign rk_idx_o    = rk_idx_q;

    always_comb begin
        state_d    = state_q;
        keystate_d = keystate_q;
        rcon_d     = rcon_q;
        wbuf_d     = wbuf_q;
        cnt_d      = cnt_q;
        rk_idx_d   = rk_idx_q;
        off        = 0;
        case (state_q)
            IDLE: begin
                if (key_valid_i) begin
                    keystate_d = key_i;
                    for (int i = 0; i < BUF_W; i++) wbuf_d[i] = '0;
                    for (int i = 0; i < NK; i++) wbuf_d[i] = key_i[KEYSIZE-1-32*i -: 32];
                    cnt_d    = 4'(NK);
                    rcon_d   = RCON_INIT;
                    rk_idx_d = 4'd0;
                    state_d  = EMIT;
                end
            end
            EMIT: begin
                if (rk_valid_o && rk_ready_i) begin
                    for (int i = 0; i < BUF_W - 4; i++) wbuf_d[i] = wbuf_q[i+4];
                    for (int i = BUF_W - 4; i < BUF_W; i++) wbuf_d[i] = '0;
                    cnt_d    = cnt_q - 4'd4;
                    rk_idx_d = rk_idx_q + 4'd1;
                    if (rk_last_o) begin
                        // Surplus words of the final step are dropped here.
                        for (int i = 0; i < BUF_W; i++) wbuf_d[i] = '0;
                        cnt_d    = 4'd0;
                        rk_idx_d = 4'd0;
                        state_d  = IDLE;
                    end else if ((cnt_q - 4'd4) < 4'd4) begin
                        state_d = EXPAND;
                    end
                end
            end
            EXPAND: begin
                keystate_d = step_out;
                for (int i = 0; i < BUF_W; i++) begin
                    off = i - int'(cnt_q);
                    if (off >= 0 && off < NK) wbuf_d[i] = step_out[KEYSIZE-1-32*off -: 32];
                end
                cnt_d   = cnt_q + 4'(NK);
                rcon_d  = xtime_f(rcon_q);
                state_d = EMIT;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q    <= IDLE;
            keystate_q <= '0;
            rcon_q     <= '0;
            wbuf_q     <= '{default: '0};
            cnt_q      <= '0;
            rk_idx_q   <= '0;
        end else begin
            state_q    <= state_d;
            keystate_q <= keystate_d;
            rcon_q     <= rcon_d;
            wbuf_q     <= wbuf_d;
            cnt_q      <= cnt_d;
            rk_idx_q   <= rk_idx_d;
        end
    end

endmodule
